// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one byte-lane RAM (one read port, one write port) between the instruction-fetch
// port and the load/store port. Round-robin arbitration; RV32I funct3 + byte address are
// converted to word address, byte enables and lane-positioned write data. Load data is
// lane-extracted and sign/zero-extended.
//
// Ports:
//   clk, rst (sync, active-low), clk_en (global enable; everything holds when low)
//   Fetch:  i_if_req, i_if_addr -> o_if_gnt, o_if_rvalid, o_if_rdata
//   Data:   i_d_req, i_d_we, i_d_funct3, i_d_addr, i_d_wdata
//           -> o_d_gnt, o_d_err, o_d_rvalid, o_d_rdata
//   RAM:    o_ram_read_req, o_ram_read_addr, i_ram_read_data (1-cycle latency),
//           o_ram_write_en, o_ram_byte_en, o_ram_write_addr, o_ram_write_data
//
// Timing: a read is granted in IDLE, the RAM returns data in the following RESP cycle
// (rvalid high). The rdata outputs are registers captured at the end of the rvalid cycle,
// so they carry the new value from the cycle after rvalid and hold until the next response.
module mem_port_arbiter #(
  parameter int unsigned RAM_AW = 5,
  parameter int unsigned XLEN   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_en,
  input  logic              i_if_req,
  input  logic [XLEN-1:0]   i_if_addr,
  output logic              o_if_gnt,
  output logic              o_if_rvalid,
  output logic [XLEN-1:0]   o_if_rdata,
  input  logic              i_d_req,
  input  logic              i_d_we,
  input  logic [2:0]        i_d_funct3,
  input  logic [XLEN-1:0]   i_d_addr,
  input  logic [XLEN-1:0]   i_d_wdata,
  output logic              o_d_gnt,
  output logic              o_d_err,
  output logic              o_d_rvalid,
  output logic [XLEN-1:0]   o_d_rdata,
  output logic              o_ram_read_req,
  output logic [RAM_AW-1:0] o_ram_read_addr,
  input  logic [31:0]       i_ram_read_data,
  output logic              o_ram_write_en,
  output logic [3:0]        o_ram_byte_en,
  output logic [RAM_AW-1:0] o_ram_write_addr,
  output logic [31:0]       o_ram_write_data
);

  typedef enum logic [0:0] {StIdle, StResp} state_e;

  localparam logic SrcFetch = 1'b0;
  localparam logic SrcData  = 1'b1;

  state_e          state_q, state_d;
  logic            rr_last_q, rr_last_d;
  logic            resp_src_q, resp_src_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [1:0]      lane_q, lane_d;
  logic [XLEN-1:0] if_rdata_q, if_rdata_d;
  logic [XLEN-1:0] d_rdata_q, d_rdata_d;

  logic            can_grant;
  logic            resp_fire;
  logic            if_win, d_win;
  logic            fn_ok, align_ok, d_legal;
  logic [7:0]      byte_sel;
  logic [15:0]     half_sel;
  logic [31:0]     load_ext;

  // Upper address bits beyond the RAM and the ignored fetch offset bits.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_if_addr[XLEN-1:RAM_AW+2], i_if_addr[1:0],
                              i_d_addr[XLEN-1:RAM_AW+2]};

  // Reset is gated into the strobes so nothing is issued while rst is held low.
  assign can_grant = rst && clk_en && (state_q == StIdle);
  assign resp_fire = rst && clk_en && (state_q == StResp);

  // On contention the port that did not win last time goes first.
  assign if_win = can_grant && i_if_req && (!i_d_req || (rr_last_q == SrcData));
  assign d_win  = can_grant && i_d_req  && (!i_if_req || (rr_last_q == SrcFetch));

  always_comb begin
    if (i_d_we) begin
      fn_ok = (i_d_funct3 == 3'b000) || (i_d_funct3 == 3'b001) || (i_d_funct3 == 3'b010);
    end else begin
      fn_ok = (i_d_funct3 == 3'b000) || (i_d_funct3 == 3'b001) || (i_d_funct3 == 3'b010) ||
              (i_d_funct3 == 3'b100) || (i_d_funct3 == 3'b101);
    end
    align_ok = (i_d_funct3[1:0] == 2'b00) ||
               ((i_d_funct3[1:0] == 2'b01) && !i_d_addr[0]) ||
               ((i_d_funct3[1:0] == 2'b10) && (i_d_addr[1:0] == 2'b00));
    d_legal  = fn_ok && align_ok;
  end

  // Load extraction from the registered RAM output using the latched lane and size.
  always_comb begin
    case (lane_q)
      2'd0:    byte_sel = i_ram_read_data[7:0];
      2'd1:    byte_sel = i_ram_read_data[15:8];
      2'd2:    byte_sel = i_ram_read_data[23:16];
      default: byte_sel = i_ram_read_data[31:24];
    endcase
    half_sel = lane_q[1] ? i_ram_read_data[31:16] : i_ram_read_data[15:0];
    case (funct3_q)
      3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  load_ext = {24'd0, byte_sel};
      3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
      3'b101:  load_ext = {16'd0, half_sel};
      default: load_ext = i_ram_read_data;
    endcase
  end

  // Grants, RAM strobes and response outputs.
  always_comb begin
    o_if_gnt         = if_win;
    o_d_gnt          = d_win;
    o_d_err          = d_win && !d_legal;
    o_if_rvalid      = resp_fire && (resp_src_q == SrcFetch);
    o_d_rvalid       = resp_fire && (resp_src_q == SrcData);
    o_ram_read_req   = 1'b0;
    o_ram_read_addr  = '0;
    o_ram_write_en   = 1'b0;
    o_ram_byte_en    = 4'b0000;
    o_ram_write_addr = '0;
    o_ram_write_data = '0;
    if (if_win) begin
      o_ram_read_req  = 1'b1;
      o_ram_read_addr = i_if_addr[RAM_AW+1:2];
    end else if (d_win && d_legal) begin
      if (i_d_we) begin
        o_ram_write_en   = 1'b1;
        o_ram_write_addr = i_d_addr[RAM_AW+1:2];
        case (i_d_funct3[1:0])
          2'b00: begin
            o_ram_byte_en    = 4'b0001 << i_d_addr[1:0];
            o_ram_write_data = {4{i_d_wdata[7:0]}};
          end
          2'b01: begin
            o_ram_byte_en    = 4'b0011 << {i_d_addr[1], 1'b0};
            o_ram_write_data = {2{i_d_wdata[15:0]}};
          end
          default: begin
            o_ram_byte_en    = 4'b1111;
            o_ram_write_data = i_d_wdata[31:0];
          end
        endcase
      end else begin
        o_ram_read_req  = 1'b1;
        o_ram_read_addr = i_d_addr[RAM_AW+1:2];
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_d    = state_q;
    rr_last_d  = rr_last_q;
    resp_src_d = resp_src_q;
    funct3_d   = funct3_q;
    lane_d     = lane_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    if (if_win) begin
      rr_last_d  = SrcFetch;
      resp_src_d = SrcFetch;
      state_d    = StResp;
    end else if (d_win) begin
      rr_last_d = SrcData;
      if (d_legal && !i_d_we) begin
        resp_src_d = SrcData;
        funct3_d   = i_d_funct3;
        lane_d     = i_d_addr[1:0];
        state_d    = StResp;
      end
    end
    if (resp_fire) begin
      state_d = StIdle;
      if (resp_src_q == SrcFetch) begin
        if_rdata_d = i_ram_read_data;
      end else begin
        d_rdata_d = load_ext;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StIdle;
      rr_last_q  <= SrcData;
      resp_src_q <= SrcFetch;
      funct3_q   <= 3'b000;
      lane_q     <= 2'b00;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      rr_last_q  <= rr_last_d;
      resp_src_q <= resp_src_d;
      funct3_q   <= funct3_d;
      lane_q     <= lane_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  assign o_if_rdata = if_rdata_q;
  assign o_d_rdata  = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst, clk_en;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req, d_we;
  logic [2:0]  d_funct3;
  logic [31:0] d_addr, d_wdata;
  logic        d_gnt, d_err, d_rvalid;
  logic [31:0] d_rdata;
  logic        ram_read_req;
  logic [4:0]  ram_read_addr;
  logic [31:0] ram_read_data;
  logic        ram_write_en;
  logic [3:0]  ram_byte_en;
  logic [4:0]  ram_write_addr;
  logic [31:0] ram_write_data;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:31];

  always #5 clk = ~clk;

  mem_port_arbiter #(.RAM_AW(5), .XLEN(32)) dut (
    .clk              (clk),
    .rst              (rst),
    .clk_en           (clk_en),
    .i_if_req         (if_req),
    .i_if_addr        (if_addr),
    .o_if_gnt         (if_gnt),
    .o_if_rvalid      (if_rvalid),
    .o_if_rdata       (if_rdata),
    .i_d_req          (d_req),
    .i_d_we           (d_we),
    .i_d_funct3       (d_funct3),
    .i_d_addr         (d_addr),
    .i_d_wdata        (d_wdata),
    .o_d_gnt          (d_gnt),
    .o_d_err          (d_err),
    .o_d_rvalid       (d_rvalid),
    .o_d_rdata        (d_rdata),
    .o_ram_read_req   (ram_read_req),
    .o_ram_read_addr  (ram_read_addr),
    .i_ram_read_data  (ram_read_data),
    .o_ram_write_en   (ram_write_en),
    .o_ram_byte_en    (ram_byte_en),
    .o_ram_write_addr (ram_write_addr),
    .o_ram_write_data (ram_write_data)
  );

  // Byte-lane RAM with registered read; contents are reloaded while rst is low.
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'h0;
      mem[4]        <= 32'hCAFEF00D;
      mem[2]        <= 32'h0BADBEEF;
      ram_read_data <= 32'h0;
    end else begin
      if (ram_read_req) ram_read_data <= mem[ram_read_addr];
      if (ram_write_en) begin
        for (int b = 0; b < 4; b++)
          if (ram_byte_en[b]) mem[ram_write_addr][8*b +: 8] <= ram_write_data[8*b +: 8];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] be, input logic [31:0] wdat,
                          input logic [4:0] waddr);
    d_req = 1'b1; d_we = 1'b1; d_funct3 = f3; d_addr = a; d_wdata = wd;
    @(negedge clk);
    chk({tag, " gnt"}, 32'(d_gnt), 32'd1);
    chk({tag, " err"}, 32'(d_err), 32'd0);
    chk({tag, " we"}, 32'(ram_write_en), 32'd1);
    chk({tag, " rreq"}, 32'(ram_read_req), 32'd0);
    chk({tag, " be"}, 32'(ram_byte_en), 32'(be));
    chk({tag, " wdata"}, ram_write_data, wdat);
    chk({tag, " waddr"}, 32'(ram_write_addr), 32'(waddr));
    step();
    d_req = 1'b0;
    @(negedge clk);
    chk({tag, " no rvalid"}, 32'(d_rvalid), 32'd0);
    step();
  endtask

  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] exp);
    d_req = 1'b1; d_we = 1'b0; d_funct3 = f3; d_addr = a;
    @(negedge clk);
    chk({tag, " gnt"}, 32'(d_gnt), 32'd1);
    chk({tag, " err"}, 32'(d_err), 32'd0);
    chk({tag, " rreq"}, 32'(ram_read_req), 32'd1);
    chk({tag, " raddr"}, 32'(ram_read_addr), 32'(a[6:2]));
    step();
    d_req = 1'b0;
    @(negedge clk);
    chk({tag, " rvalid"}, 32'(d_rvalid), 32'd1);
    step();
    @(negedge clk);
    chk({tag, " rdata"}, d_rdata, exp);
    chk({tag, " rvalid low"}, 32'(d_rvalid), 32'd0);
    step();
  endtask

  task automatic do_illegal(input string tag, input logic we, input logic [2:0] f3,
                            input logic [31:0] a);
    d_req = 1'b1; d_we = we; d_funct3 = f3; d_addr = a; d_wdata = 32'hFFFFFFFF;
    @(negedge clk);
    chk({tag, " gnt"}, 32'(d_gnt), 32'd1);
    chk({tag, " err"}, 32'(d_err), 32'd1);
    chk({tag, " rreq"}, 32'(ram_read_req), 32'd0);
    chk({tag, " we"}, 32'(ram_write_en), 32'd0);
    step();
    d_req = 1'b0;
    @(negedge clk);
    chk({tag, " no rvalid"}, 32'(d_rvalid), 32'd0);
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; clk_en = 1'b1;
    if_req = 1'b1; if_addr = 32'h10;
    d_req = 1'b1; d_we = 1'b0; d_funct3 = 3'b010; d_addr = 32'h8; d_wdata = 32'h0;

    // Reset held with both requests high.
    @(negedge clk);
    chk("rst if_gnt", 32'(if_gnt), 32'd0);
    chk("rst d_gnt", 32'(d_gnt), 32'd0);
    chk("rst rreq", 32'(ram_read_req), 32'd0);
    chk("rst we", 32'(ram_write_en), 32'd0);
    chk("rst d_err", 32'(d_err), 32'd0);
    chk("rst if_rvalid", 32'(if_rvalid), 32'd0);
    chk("rst d_rvalid", 32'(d_rvalid), 32'd0);
    @(negedge clk);
    chk("rst if_rdata", if_rdata, 32'h0);
    chk("rst d_rdata", d_rdata, 32'h0);
    chk("rst2 if_gnt", 32'(if_gnt), 32'd0);
    step();
    rst = 1'b1;

    // Contention: fetch first, then data, fetch, data.
    @(negedge clk);
    chk("rr1 if_gnt", 32'(if_gnt), 32'd1);
    chk("rr1 d_gnt", 32'(d_gnt), 32'd0);
    chk("rr1 rreq", 32'(ram_read_req), 32'd1);
    chk("rr1 raddr", 32'(ram_read_addr), 32'd4);
    step();
    @(negedge clk);
    chk("rr1 if_rvalid", 32'(if_rvalid), 32'd1);
    chk("rr1 d_rvalid", 32'(d_rvalid), 32'd0);
    chk("resp if_gnt", 32'(if_gnt), 32'd0);
    chk("resp d_gnt", 32'(d_gnt), 32'd0);
    chk("resp rreq", 32'(ram_read_req), 32'd0);
    step();
    @(negedge clk);
    chk("rr2 d_gnt", 32'(d_gnt), 32'd1);
    chk("rr2 if_gnt", 32'(if_gnt), 32'd0);
    chk("rr2 raddr", 32'(ram_read_addr), 32'd2);
    chk("rr1 if_rdata", if_rdata, 32'hCAFEF00D);
    chk("rr2 if_rvalid low", 32'(if_rvalid), 32'd0);
    step();
    @(negedge clk);
    chk("rr2 d_rvalid", 32'(d_rvalid), 32'd1);
    chk("rr2 if_rvalid", 32'(if_rvalid), 32'd0);
    step();
    @(negedge clk);
    chk("rr3 if_gnt", 32'(if_gnt), 32'd1);
    chk("rr3 d_gnt", 32'(d_gnt), 32'd0);
    chk("rr2 d_rdata", d_rdata, 32'h0BADBEEF);
    step();
    @(negedge clk);
    chk("rr3 if_rvalid", 32'(if_rvalid), 32'd1);
    step();
    @(negedge clk);
    chk("rr4 d_gnt", 32'(d_gnt), 32'd1);
    chk("rr4 if_gnt", 32'(if_gnt), 32'd0);
    step();
    if_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
    chk("rr4 d_rvalid", 32'(d_rvalid), 32'd1);
    step();

    // Stores and loads through the lane logic.
    do_store("SB", 3'b000, 32'h6, 32'h000000AB, 4'b0100, 32'hABABABAB, 5'd1);
    do_load("LB", 3'b000, 32'h6, 32'hFFFFFFAB);
    do_load("LBU", 3'b100, 32'h6, 32'h000000AB);
    do_store("SH", 3'b001, 32'h2, 32'h00008001, 4'b1100, 32'h80018001, 5'd0);
    do_load("LH", 3'b001, 32'h2, 32'hFFFF8001);
    do_load("LHU", 3'b101, 32'h2, 32'h00008001);
    do_store("SW", 3'b010, 32'h8, 32'h12345678, 4'b1111, 32'h12345678, 5'd2);
    do_load("LW", 3'b010, 32'h8, 32'h12345678);

    // Illegal accesses.
    do_illegal("LW mis", 1'b0, 3'b010, 32'h5);
    do_illegal("LH mis", 1'b0, 3'b001, 32'h3);
    do_illegal("L f3=011", 1'b0, 3'b011, 32'h0);
    do_illegal("S f3=100", 1'b1, 3'b100, 32'h0);

    // Pending response held across clk_en low.
    d_req = 1'b1; d_we = 1'b0; d_funct3 = 3'b000; d_addr = 32'hB;
    @(negedge clk);
    chk("ce gnt", 32'(d_gnt), 32'd1);
    step();
    d_req = 1'b0; clk_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("ce held rvalid", 32'(d_rvalid), 32'd0);
      step();
    end
    clk_en = 1'b1;
    @(negedge clk);
    chk("ce rvalid", 32'(d_rvalid), 32'd1);
    step();
    @(negedge clk);
    chk("ce rdata", d_rdata, 32'h00000012);
    chk("ce rvalid once", 32'(d_rvalid), 32'd0);
    step();

    // Reset while in RESP drops the response.
    d_req = 1'b1; d_we = 1'b0; d_funct3 = 3'b010; d_addr = 32'h8;
    @(negedge clk);
    chk("rr gnt", 32'(d_gnt), 32'd1);
    step();
    d_req = 1'b0; rst = 1'b0;
    @(negedge clk);
    chk("rr rvalid in rst", 32'(d_rvalid), 32'd0);
    step();
    rst = 1'b1;
    @(negedge clk);
    chk("rr rvalid after", 32'(d_rvalid), 32'd0);
    chk("rr rdata cleared", d_rdata, 32'h0);
    step();
    @(negedge clk);
    chk("rr rvalid later", 32'(d_rvalid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
